mem_access_unit: RTL and testbench

- Load/store front-end sitting directly upstream of the word-addressed data memory (DataMem); driven by the core's MEM stage.
- Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses.
- Sub-word stores use a read-modify-write sequence.
- Returns sign/zero-extended load data and error flags over a valid/ready response handshake.

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front-end for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional macro MEM_RANGE_CHECK_EN: fault requests whose address lies above the memory's byte range.
module mem_access_unit #(
  parameter int WORD_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_misaligned,
  output logic               resp_fault,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [WORD_AW+1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          merged_q, merged_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_mis_q, resp_mis_d;
  logic                 resp_fault_q, resp_fault_d;

  logic                 illegal;
  logic                 misaligned;
  logic                 out_of_range;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F_B:     r = {{24{b[7]}}, b};
      F_H:     r = {{16{h[15]}}, h};
      F_BU:    r = {24'h0, b};
      F_HU:    r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (f3 == F_B)  r[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1]) r[31:16] = wd[15:0];
    else             r[15:0]  = wd[15:0];
    return r;
  endfunction

`ifdef MEM_RANGE_CHECK_EN
  assign out_of_range = |req_addr[31:WORD_AW+2];
`else
  // Upper address bits wrap; they are deliberately left unused.
  logic unused_addr_hi;
  assign out_of_range   = 1'b0;
  assign unused_addr_hi = ^req_addr[31:WORD_AW+2];
`endif

  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      F_B, F_H, F_W: illegal = 1'b0;
      F_BU, F_HU:    illegal = req_we;
      default:       illegal = 1'b1;
    endcase
    misaligned = !illegal &&
                 ((((req_funct3 == F_H) || (req_funct3 == F_HU)) && req_addr[0]) ||
                  ((req_funct3 == F_W) && (req_addr[1:0] != 2'b00)));
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    resp_fault_d = resp_fault_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = 32'h0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d         = req_we;
          funct3_d     = req_funct3;
          addr_d       = req_addr[WORD_AW+1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = 32'h0;
          resp_mis_d   = misaligned;
          resp_fault_d = illegal || out_of_range;
          state_d      = (misaligned || illegal || out_of_range) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          mem_read     = 1'b1;
          resp_rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
          state_d      = RESP;
        end else if (funct3_q == F_W) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
          state_d   = RESP;
        end else begin
          // Sub-word store: read the current word and splice in the new lane.
          mem_read = 1'b1;
          merged_d = store_merge(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_wdata = merged_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must never touch memory, even mid-transaction.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign mem_addr        = addr_q[WORD_AW+1:2];
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_fault      = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vector table, a reset-abort sequence and randomized traffic vs a reference model.
module tb_mem_access_unit;
  localparam int WORD_AW = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid, req_ready, req_we;
  logic [2:0]         req_funct3;
  logic [31:0]        req_addr, req_wdata;
  logic               resp_valid, resp_ready;
  logic [31:0]        resp_rdata;
  logic               resp_misaligned, resp_fault;
  logic               mem_read, mem_write;
  logic [WORD_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata, mem_rdata;

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[$];

  mem_access_unit #(.WORD_AW(WORD_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int hold, input logic [31:0] rd,
                              input logic mis, input logic flt, input int lat, input int nrd,
                              input int nwr, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.hold = hold;
    v.rd = rd; v.mis = mis; v.flt = flt; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wd = wd;
    return v;
  endfunction

  // Reference: architectural meaning of the access, plus the promised latency and memory traffic.
  function automatic void ref_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd,
                                  output logic mis, output logic flt, output int lat,
                                  output int nrd, output int nwr, output logic [31:0] wd);
    int nbytes, w, off;
    bit legal, oor;
    logic [31:0] old, val, mask;
    rd = 0; mis = 0; flt = 0; lat = 1; nrd = 0; nwr = 0; wd = 0;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    nbytes = 0;
    endcase
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    oor = 0;
`ifdef MEM_RANGE_CHECK_EN
    oor = (addr >> 8) != 0;
`endif
    if (!legal) begin flt = 1; return; end
    mis = (addr % nbytes) != 0;
    flt = oor;
    if (mis || flt) return;
    w = int'((addr >> 2) % 64);
    off = int'(addr % 4);
    old = ref_mem[w];
    if (!we) begin
      lat = 2; nrd = 1;
      val = old >> (8 * off);
      if (nbytes == 1) begin
        val = val & 32'hFF;
        if (f3 == 3'd0 && val[7]) val = val | 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        val = val & 32'hFFFF;
        if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
      end
      rd = val;
    end else if (nbytes == 4) begin
      lat = 2; nwr = 1; wd = wdata; ref_mem[w] = wdata;
    end else begin
      lat = 3; nrd = 1; nwr = 1;
      mask = ((nbytes == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
      wd = (old & ~mask) | ((wdata << (8 * off)) & mask);
      ref_mem[w] = wd;
    end
  endfunction

  task automatic run_check(input vec_t v, input string tag);
    int lat, nrd, nwr, both, badaddr;
    logic [31:0] wd;
    logic [WORD_AW-1:0] exp_wa;
    exp_wa = v.addr[WORD_AW+1:2];
    lat = 0; nrd = 0; nwr = 0; both = 0; badaddr = 0; wd = 0;
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    resp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wd = mem_wdata; end
      if (mem_read && mem_write) both++;
      if ((mem_read || mem_write) && mem_addr != exp_wa) badaddr++;
      if (resp_valid || lat >= 10) break;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
    chk({tag, ".rdata"}, resp_rdata, v.rd);
    chk({tag, ".misaligned"}, 32'(resp_misaligned), 32'(v.mis));
    chk({tag, ".fault"}, 32'(resp_fault), 32'(v.flt));
    chk({tag, ".mem_reads"}, 32'(nrd), 32'(v.nrd));
    chk({tag, ".mem_writes"}, 32'(nwr), 32'(v.nwr));
    chk({tag, ".rd_wr_overlap"}, 32'(both), 32'd0);
    chk({tag, ".mem_addr"}, 32'(badaddr), 32'd0);
    if (v.nwr > 0) chk({tag, ".mem_wdata"}, wd, v.wd);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, v.rd);
      chk({tag, ".hold_flags"}, {30'd0, resp_misaligned, resp_fault}, {30'd0, v.mis, v.flt});
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    @(negedge clk);
    chk({tag, ".back_idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] rd, wd, a;
    logic mis, flt;
    int lat, nrd, nwr, x, nb;
    vec_t v;

    for (int i = 0; i < 64; i++) begin dmem[i] = 0; ref_mem[i] = 0; end
    dmem[0] = 32'd17; dmem[1] = 32'd9; dmem[2] = 32'd25;
    ref_mem[0] = 32'd17; ref_mem[1] = 32'd9; ref_mem[2] = 32'd25;
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.resp", {29'd0, resp_valid, resp_misaligned, resp_fault}, 32'd0);
    chk("reset.rdata", resp_rdata, 32'd0);
    chk("reset.mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);

    tbl.push_back(mk(0, 3'd2, 32'h08, 0, 0, 32'h19, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 3'd0, 32'h05, 32'hAB, 0, 0, 0, 0, 3, 1, 1, 32'h0000AB09));
    tbl.push_back(mk(0, 3'd2, 32'h04, 0, 0, 32'h0000AB09, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd0, 32'h05, 0, 0, 32'hFFFFFFAB, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd4, 32'h05, 0, 0, 32'h000000AB, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd1, 32'h03, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h00, 0, 3, 32'h11, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd3, 32'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0));
`ifdef MEM_RANGE_CHECK_EN
    tbl.push_back(mk(0, 3'd2, 32'h100, 0, 0, 0, 0, 1, 1, 0, 0, 0));
`else
    tbl.push_back(mk(0, 3'd2, 32'h100, 0, 0, 32'h11, 0, 0, 2, 1, 0, 0));
`endif
    tbl.push_back(mk(1, 3'd1, 32'h06, 32'hBEEF, 0, 0, 0, 0, 3, 1, 1, 32'hBEEFAB09));
    tbl.push_back(mk(0, 3'd1, 32'h06, 0, 0, 32'hFFFFBEEF, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd5, 32'h06, 0, 0, 32'h0000BEEF, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 3'd4, 32'h10, 32'h55, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h0C, 32'hDEADBEEF, 1, 0, 0, 0, 2, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'd2, 32'h0C, 0, 0, 32'hDEADBEEF, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h0E, 32'h1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 32'h0F, 0, 0, 32'hFFFFFFDE, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd1, 32'h0E, 0, 2, 32'hFFFFDEAD, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 3'd0, 32'h0C, 32'h123, 0, 0, 0, 0, 3, 1, 1, 32'hDEADBE23));
    tbl.push_back(mk(0, 3'd4, 32'h0C, 0, 0, 32'h23, 0, 0, 2, 1, 0, 0));

    foreach (tbl[i]) begin
      ref_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, mis, flt, lat, nrd, nwr, wd);
      run_check(tbl[i], $sformatf("vec%0d", i));
    end

    // SH abandoned by reset while in the write cycle.
    req_valid = 1; req_we = 1; req_funct3 = 3'd1; req_addr = 32'h08; req_wdata = 32'h1234;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstwr.mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rstwr.word2", dmem[2], 32'd25);
    chk("rstwr.req_ready", 32'(req_ready), 32'd1);
    chk("rstwr.resp", {29'd0, resp_valid, resp_misaligned, resp_fault}, 32'd0);
    chk("rstwr.rdata", resp_rdata, 32'd0);
    chk("rstwr.mem_out", {mem_wdata | 32'(mem_addr)}, 32'd0);
    run_check(mk(0, 3'd2, 32'h08, 0, 0, 32'h19, 0, 0, 2, 1, 0, 0), "rstwr.lw");

    for (int i = 0; i < 200; i++) begin
      v.we = 1'($urandom_range(0, 1));
      x = $urandom_range(0, 9);
      case (x)
        0, 5: v.f3 = 3'd0;
        1, 6: v.f3 = 3'd1;
        2, 7: v.f3 = 3'd2;
        3:    v.f3 = 3'd4;
        4:    v.f3 = 3'd5;
        8:    v.f3 = 3'd3;
        default: v.f3 = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7;
      endcase
      nb = (v.f3 == 3'd2) ? 4 : ((v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 1);
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(8, 31));
      v.addr = a;
      v.wdata = $urandom;
      v.hold = $urandom_range(0, 2);
      ref_txn(v.we, v.f3, v.addr, v.wdata, rd, mis, flt, lat, nrd, nwr, wd);
      v.rd = rd; v.mis = mis; v.flt = flt; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wd = wd;
      run_check(v, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 64; i++) chk($sformatf("final.word%0d", i), dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
